symbol_error_counter: RTL

//  Downstream of the receiver slicers: compares recovered 2-bit I/Q symbols

---
 rtl/symbol_error_counter.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/symbol_error_counter.sv
// Symbol error counter: compares sliced rx I/Q symbols against a delayed copy of
// the tx reference and accumulates per-rail and complex symbol errors over a fixed window.
module symbol_error_counter #(
  parameter int DLY_W      = 5,
  parameter int FLUSH_SYMS = 32,
  parameter int WIN_LOG2   = 10,
  parameter int CNT_W      = 11
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sym_clk_ena,
  input  logic                start,
  input  logic [DLY_W-1:0]    delay_sel,
  input  logic [1:0]          tx_syms_i,
  input  logic [1:0]          tx_syms_q,
  input  logic [1:0]          rx_syms_i,
  input  logic [1:0]          rx_syms_q,
  output logic [CNT_W-1:0]    err_count_i,
  output logic [CNT_W-1:0]    err_count_q,
  output logic [CNT_W-1:0]    err_count,
  output logic [WIN_LOG2:0]   sym_count,
  output logic                busy,
  output logic                done
);

  localparam int DEPTH = 2**DLY_W - 1;
  localparam int FL_W  = $clog2(FLUSH_SYMS + 1);
  localparam int SYM_W = WIN_LOG2 + 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FLUSH   = 2'd1,
    ST_MEASURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  // Reference delay line, {i,q} packed per entry; entry gi holds tx delayed by gi+1 symbols.
  logic [3:0] dly_reg [DEPTH];
  logic [3:0] tap_vec [DEPTH+1];

  assign tap_vec[0] = {tx_syms_i, tx_syms_q};

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_dly
      if (gi == 0) begin : g_first
        always_ff @(posedge clk) begin
          if (reset)
            dly_reg[gi] <= 4'b0000;
          else if (sym_clk_ena)
            dly_reg[gi] <= {tx_syms_i, tx_syms_q};
        end
      end else begin : g_rest
        always_ff @(posedge clk) begin
          if (reset)
            dly_reg[gi] <= 4'b0000;
          else if (sym_clk_ena)
            dly_reg[gi] <= dly_reg[gi-1];
        end
      end
      assign tap_vec[gi+1] = dly_reg[gi];
    end
  endgenerate

  logic [3:0] ref_sym;
  logic       miss_i;
  logic       miss_q;

  assign ref_sym = tap_vec[delay_sel];
  assign miss_i  = (rx_syms_i != ref_sym[3:2]);
  assign miss_q  = (rx_syms_q != ref_sym[1:0]);

  state_t            state_reg, state_next;
  logic [FL_W-1:0]   flush_cnt_reg, flush_cnt_next;
  logic [SYM_W-1:0]  sym_count_reg, sym_count_next;
  logic [CNT_W-1:0]  err_i_reg, err_i_next;
  logic [CNT_W-1:0]  err_q_reg, err_q_next;
  logic [CNT_W-1:0]  err_reg, err_next;
  logic              busy_reg, busy_next;
  logic              done_reg, done_next;

  // Saturating increment; holds at all-ones rather than wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt, input logic inc);
    logic [CNT_W-1:0] res;
    res = cnt;
    if (inc && (cnt != {CNT_W{1'b1}}))
      res = cnt + 1'b1;
    return res;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      flush_cnt_reg <= '0;
      sym_count_reg <= '0;
      err_i_reg     <= '0;
      err_q_reg     <= '0;
      err_reg       <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      flush_cnt_reg <= flush_cnt_next;
      sym_count_reg <= sym_count_next;
      err_i_reg     <= err_i_next;
      err_q_reg     <= err_q_next;
      err_reg       <= err_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    flush_cnt_next = flush_cnt_reg;
    sym_count_next = sym_count_reg;
    err_i_next     = err_i_reg;
    err_q_next     = err_q_reg;
    err_next       = err_reg;
    busy_next      = busy_reg;
    done_next      = done_reg;

    case (state_reg)
      ST_IDLE, ST_DONE: begin
        // A strobe coincident with start is deliberately not counted toward the flush.
        if (start) begin
          state_next     = ST_FLUSH;
          flush_cnt_next = '0;
          sym_count_next = '0;
          err_i_next     = '0;
          err_q_next     = '0;
          err_next       = '0;
          busy_next      = 1'b1;
          done_next      = 1'b0;
        end
      end
      ST_FLUSH: begin
        if (sym_clk_ena) begin
          if (flush_cnt_reg == FL_W'(FLUSH_SYMS - 1)) begin
            state_next     = ST_MEASURE;
            flush_cnt_next = '0;
          end else begin
            flush_cnt_next = flush_cnt_reg + 1'b1;
          end
        end
      end
      ST_MEASURE: begin
        if (sym_clk_ena) begin
          sym_count_next = sym_count_reg + 1'b1;
          err_i_next     = sat_inc(err_i_reg, miss_i);
          err_q_next     = sat_inc(err_q_reg, miss_q);
          err_next       = sat_inc(err_reg, miss_i | miss_q);
          if (sym_count_reg == SYM_W'(2**WIN_LOG2 - 1)) begin
            state_next = ST_DONE;
            busy_next  = 1'b0;
            done_next  = 1'b1;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
        busy_next  = 1'b0;
        done_next  = 1'b0;
      end
    endcase
  end

  assign err_count_i = err_i_reg;
  assign err_count_q = err_q_reg;
  assign err_count   = err_reg;
  assign sym_count   = sym_count_reg;
  assign busy        = busy_reg;
  assign done        = done_reg;

endmodule
